mem_port_arbiter: RTL and testbench

//  Shares the single unified instruction/data memory port of the multi-cycle RISC-V core

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_port_arbiter_chk.sv | 26 ++
 rtl/rr_arbiter2.sv | 27 ++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory port arbiter.
// Requester ids double as indices into the {m1, m0} request/grant vectors.
package mem_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    REQ_M0 = 1'b0,
    REQ_M1 = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_port_arbiter_chk.sv
// Protocol properties of the memory port arbiter, bound in by the top.
// Checked only while out of reset.
module mem_port_arbiter_chk (
  input logic clk,
  input logic rst,
  input logic m0_gnt,
  input logic m1_gnt,
  input logic m0_rvalid,
  input logic m1_rvalid,
  input logic mem_we,
  input logic idle
);

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0({m1_gnt, m0_gnt}));

  a_rvalid_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0({m1_rvalid, m0_rvalid}));

  a_we_needs_gnt: assert property (@(posedge clk) disable iff (rst)
    mem_we |-> (m0_gnt || m1_gnt));

  a_gnt_only_idle: assert property (@(posedge clk) disable iff (rst)
    (m0_gnt || m1_gnt) |-> idle);

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: one-hot grant, ties go to the requester
// that did not win last time. Purely combinational.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_gnt,
  input  logic       enable,
  output logic [1:0] gnt
);

  // Select the winner among active requests when enabled.
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_gnt == REQ_M0) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end else begin
      gnt = 2'b00;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM port between the core (M0) and the debug loader (M1),
// one access at a time, and returns read data with a single-cycle valid pulse.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                CNT_W    = $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_id_t          last_gnt_q, last_gnt_d;
  req_id_t          rd_owner_q, rd_owner_d;
  logic [1:0]       gnt_s;
  logic             idle_s;
  req_id_t          win_s;

  // Grants are suppressed while reset is held so nothing reaches the RAM.
  assign idle_s = (state_q == IDLE) && !rst;

  rr_arbiter2 u_rr (
    .req      ({m1_req, m0_req}),
    .last_gnt (last_gnt_q),
    .enable   (idle_s),
    .gnt      (gnt_s)
  );

  assign m0_gnt   = gnt_s[0];
  assign m1_gnt   = gnt_s[1];
  assign m0_rdata = mem_rdata;
  assign m1_rdata = mem_rdata;

  // Next-state, latency counting and the RAM-side mux.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    rd_owner_d = rd_owner_q;
    win_s      = gnt_s[1] ? REQ_M1 : REQ_M0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_s != 2'b00) begin
          if (win_s == REQ_M1) begin
            mem_addr  = m1_addr;
            mem_we    = m1_we;
            mem_wdata = m1_wdata;
          end else begin
            mem_addr  = m0_addr;
            mem_we    = m0_we;
            mem_wdata = m0_wdata;
          end
          last_gnt_d = win_s;
          // Writes complete in the grant cycle; only reads occupy the port.
          if (!mem_we) begin
            state_d    = RD_WAIT;
            cnt_d      = CNT_ONE;
            rd_owner_d = win_s;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          if (!rst) begin
            m0_rvalid = (rd_owner_q == REQ_M0);
            m1_rvalid = (rd_owner_q == REQ_M1);
          end else begin
            m0_rvalid = 1'b0;
            m1_rvalid = 1'b0;
          end
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset leaves M0 as the first tie winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_gnt_q <= REQ_M1;
      rd_owner_q <= REQ_M0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  mem_port_arbiter_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .m0_gnt    (m0_gnt),
    .m1_gnt    (m1_gnt),
    .m0_rvalid (m0_rvalid),
    .m1_rvalid (m1_rvalid),
    .mem_we    (mem_we),
    .idle      (state_q == IDLE)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance A uses READ_LAT=1, instance B READ_LAT=3,
// each with its own small RAM model; directed scenarios plus a randomized run on A.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic        a_m0_req, a_m0_we, a_m1_req, a_m1_we;
  logic [31:0] a_m0_addr, a_m0_wdata, a_m1_addr, a_m1_wdata;
  logic        a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_mem_we;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;

  logic        b_m0_req, b_m0_we, b_m1_req, b_m1_we;
  logic [31:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata;
  logic        b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_mem_we;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
    .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
    .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
    .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
    .mem_addr(a_mem_addr), .mem_we(a_mem_we), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  logic [31:0] ram_a [256];
  logic [31:0] ram_b [256];
  logic [31:0] pipe_b0, pipe_b1;

  // RAM A: one cycle read latency, cleared on reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram_a[i] <= 32'h0;
    end else if (a_mem_we) begin
      ram_a[a_mem_addr[9:2]] <= a_mem_wdata;
    end
    a_mem_rdata <= ram_a[a_mem_addr[9:2]];
  end

  // RAM B: three cycle read latency, cleared on reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram_b[i] <= 32'h0;
    end else if (b_mem_we) begin
      ram_b[b_mem_addr[9:2]] <= b_mem_wdata;
    end
    pipe_b0     <= ram_b[b_mem_addr[9:2]];
    pipe_b1     <= pipe_b0;
    b_mem_rdata <= pipe_b1;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 32'h20;
    a_m1_req = 1'b1; a_m1_we = 1'b0; a_m1_addr = 32'h24;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({a_m1_gnt, a_m0_gnt} !== 2'b00) begin
        errors++; $display("FAIL reset_gnt: got %b want 00", {a_m1_gnt, a_m0_gnt});
      end
      checks++;
      if (a_mem_we !== 1'b0 || a_mem_addr !== 32'h0) begin
        errors++; $display("FAIL reset_mem: we=%b addr=%h want 0/0", a_mem_we, a_mem_addr);
      end
      checks++;
      if ({a_m1_rvalid, a_m0_rvalid} !== 2'b00) begin
        errors++; $display("FAIL reset_rvalid: got %b want 00", {a_m1_rvalid, a_m0_rvalid});
      end
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_m1_gnt, a_m0_gnt} !== 2'b01) begin
      errors++; $display("FAIL reset_first_gnt: got %b want 01", {a_m1_gnt, a_m0_gnt});
    end
    next_cycle();
    a_m0_req = 1'b0; a_m1_req = 1'b0;
    repeat (3) next_cycle();
  endtask

  task automatic test_read();
    a_m1_req = 1'b1; a_m1_we = 1'b1; a_m1_addr = 32'h10; a_m1_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (a_m1_gnt !== 1'b1 || a_mem_we !== 1'b1 || a_mem_addr !== 32'h10) begin
      errors++; $display("FAIL preload_wr: gnt=%b we=%b addr=%h want 1/1/10", a_m1_gnt, a_mem_we, a_mem_addr);
    end
    next_cycle();
    a_m1_req = 1'b0; a_m1_we = 1'b0;
    a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 32'h10;
    @(negedge clk);
    checks++;
    if (a_m0_gnt !== 1'b1 || a_mem_we !== 1'b0 || a_mem_addr !== 32'h10) begin
      errors++; $display("FAIL read_gnt: gnt=%b we=%b addr=%h want 1/0/10", a_m0_gnt, a_mem_we, a_mem_addr);
    end
    checks++;
    if ({a_m1_rvalid, a_m0_rvalid} !== 2'b00) begin
      errors++; $display("FAIL read_early_rvalid: got %b want 00", {a_m1_rvalid, a_m0_rvalid});
    end
    next_cycle();
    a_m0_req = 1'b0;
    @(negedge clk);
    checks++;
    if (a_m0_rvalid !== 1'b1 || a_m0_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_data: rvalid=%b rdata=%h want 1/deadbeef", a_m0_rvalid, a_m0_rdata);
    end
    checks++;
    if (a_m1_rvalid !== 1'b0 || a_m0_gnt !== 1'b0) begin
      errors++; $display("FAIL read_side: m1_rvalid=%b m0_gnt=%b want 0/0", a_m1_rvalid, a_m0_gnt);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({a_m1_rvalid, a_m0_rvalid} !== 2'b00) begin
      errors++; $display("FAIL read_pulse: got %b want 00", {a_m1_rvalid, a_m0_rvalid});
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d0, d1, last0, last1;
    logic        exp_m1;
    d0 = 32'h1000; d1 = 32'h2000; last0 = 32'h0; last1 = 32'h0;
    exp_m1 = 1'b1;  // M0 took the previous grant
    a_m0_req = 1'b1; a_m0_we = 1'b1; a_m0_addr = 32'h100; a_m0_wdata = d0;
    a_m1_req = 1'b1; a_m1_we = 1'b1; a_m1_addr = 32'h200; a_m1_wdata = d1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({a_m1_gnt, a_m0_gnt} !== {exp_m1, ~exp_m1}) begin
        errors++; $display("FAIL b2b_gnt[%0d]: got %b want %b", i, {a_m1_gnt, a_m0_gnt}, {exp_m1, ~exp_m1});
      end
      checks++;
      if (a_mem_we !== 1'b1 || a_mem_addr !== (exp_m1 ? 32'h200 : 32'h100) ||
          a_mem_wdata !== (exp_m1 ? d1 : d0)) begin
        errors++; $display("FAIL b2b_mem[%0d]: we=%b addr=%h wdata=%h", i, a_mem_we, a_mem_addr, a_mem_wdata);
      end
      next_cycle();
      if (exp_m1) begin
        last1 = d1; d1 = d1 + 32'd1; a_m1_wdata = d1;
      end else begin
        last0 = d0; d0 = d0 + 32'd1; a_m0_wdata = d0;
      end
      exp_m1 = ~exp_m1;
    end
    a_m0_req = 1'b0; a_m1_req = 1'b0; a_m0_we = 1'b0; a_m1_we = 1'b0;
    @(negedge clk);
    checks++;
    if (ram_a[64] !== last0 || ram_a[128] !== last1) begin
      errors++; $display("FAIL b2b_ram: got %h/%h want %h/%h", ram_a[64], ram_a[128], last0, last1);
    end
    checks++;
    if ({a_m1_gnt, a_m0_gnt} !== 2'b00) begin
      errors++; $display("FAIL b2b_idle_gnt: got %b want 00", {a_m1_gnt, a_m0_gnt});
    end
    next_cycle();
  endtask

  task automatic test_lat3_contention();
    b_m1_req = 1'b1; b_m1_we = 1'b1; b_m1_addr = 32'h40; b_m1_wdata = 32'hCAFEF00D;
    @(negedge clk);
    checks++;
    if (b_m1_gnt !== 1'b1) begin
      errors++; $display("FAIL lat3_preload: gnt=%b want 1", b_m1_gnt);
    end
    next_cycle();
    b_m1_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({b_m1_gnt, b_m0_gnt} !== 2'b10 || b_mem_addr !== 32'h40) begin
      errors++; $display("FAIL lat3_rd_gnt: gnt=%b addr=%h want 10/40", {b_m1_gnt, b_m0_gnt}, b_mem_addr);
    end
    next_cycle();
    b_m1_req = 1'b0;
    b_m0_req = 1'b1; b_m0_we = 1'b1; b_m0_addr = 32'h44; b_m0_wdata = 32'h5555AAAA;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (b_m0_gnt !== 1'b0 || b_mem_we !== 1'b0 || b_mem_addr !== 32'h0) begin
        errors++; $display("FAIL lat3_wait[%0d]: gnt=%b we=%b addr=%h want 0/0/0", k, b_m0_gnt, b_mem_we, b_mem_addr);
      end
      checks++;
      if ({b_m1_rvalid, b_m0_rvalid} !== {(k == 3), 1'b0}) begin
        errors++; $display("FAIL lat3_rvalid[%0d]: got %b want %b", k, {b_m1_rvalid, b_m0_rvalid}, {(k == 3), 1'b0});
      end
      if (k == 3) begin
        checks++;
        if (b_m1_rdata !== 32'hCAFEF00D) begin
          errors++; $display("FAIL lat3_rdata: got %h want cafef00d", b_m1_rdata);
        end
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (b_m0_gnt !== 1'b1 || b_mem_we !== 1'b1) begin
      errors++; $display("FAIL lat3_m0_after: gnt=%b we=%b want 1/1", b_m0_gnt, b_mem_we);
    end
    next_cycle();
    b_m0_req = 1'b0; b_m0_we = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    b_m0_req = 1'b1; b_m0_we = 1'b0; b_m0_addr = 32'h44;
    @(negedge clk);
    checks++;
    if (b_m0_gnt !== 1'b1) begin
      errors++; $display("FAIL mid_rst_gnt: got %b want 1", b_m0_gnt);
    end
    next_cycle();
    b_m0_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({b_m1_gnt, b_m0_gnt, b_m1_rvalid, b_m0_rvalid, b_mem_we} !== 5'b00000) begin
      errors++; $display("FAIL mid_rst_hold: gnt=%b rvalid=%b we=%b", {b_m1_gnt, b_m0_gnt}, {b_m1_rvalid, b_m0_rvalid}, b_mem_we);
    end
    next_cycle();
    rst = 1'b0;
    b_m1_req = 1'b1; b_m1_we = 1'b1; b_m1_addr = 32'h48; b_m1_wdata = 32'h12345678;
    @(negedge clk);
    checks++;
    if (b_m1_gnt !== 1'b1 || b_mem_we !== 1'b1) begin
      errors++; $display("FAIL mid_rst_idle: gnt=%b we=%b want 1/1", b_m1_gnt, b_mem_we);
    end
    next_cycle();
    b_m1_req = 1'b0; b_m1_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({b_m1_rvalid, b_m0_rvalid} !== 2'b00) begin
        errors++; $display("FAIL mid_rst_no_rvalid[%0d]: got %b want 00", k, {b_m1_rvalid, b_m0_rvalid});
      end
      next_cycle();
    end
  endtask

  // Transaction-level model: a grant makes the port busy until a cycle number,
  // reads return the model memory READ_LAT cycles later.
  task automatic test_random();
    localparam int LAT = 1;
    logic [31:0] mdl [256];
    logic        p0, p1, we0, we1, win, last, gnt_any;
    logic [31:0] ad0, ad1, wd0, wd1, eaddr, ewdata, rv_data;
    logic        ewe, rv_owner;
    int          free_at, rv_at;
    for (int i = 0; i < 256; i++) mdl[i] = 32'h0;
    p0 = 1'b0; p1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    ad0 = 32'h0; ad1 = 32'h0; wd0 = 32'h0; wd1 = 32'h0;
    last = 1'b1; free_at = 0; rv_at = -1; rv_owner = 1'b0; rv_data = 32'h0;
    for (int c = 0; c < 400; c++) begin
      if (!p0 && $urandom_range(0, 99) < 60) begin
        p0 = 1'b1; we0 = 1'($urandom_range(0, 1));
        ad0 = 32'($urandom_range(0, 15)) * 32'd4; wd0 = $urandom;
      end else if (p0 && $urandom_range(0, 99) < 5) begin
        p0 = 1'b0;
      end
      if (!p1 && $urandom_range(0, 99) < 60) begin
        p1 = 1'b1; we1 = 1'($urandom_range(0, 1));
        ad1 = 32'($urandom_range(0, 15)) * 32'd4; wd1 = $urandom;
      end else if (p1 && $urandom_range(0, 99) < 5) begin
        p1 = 1'b0;
      end
      a_m0_req = p0; a_m0_we = we0; a_m0_addr = ad0; a_m0_wdata = wd0;
      a_m1_req = p1; a_m1_we = we1; a_m1_addr = ad1; a_m1_wdata = wd1;
      @(negedge clk);
      gnt_any = (c >= free_at) && (p0 || p1);
      win = (p0 && p1) ? ~last : p1;
      eaddr = gnt_any ? (win ? ad1 : ad0) : 32'h0;
      ewe = gnt_any ? (win ? we1 : we0) : 1'b0;
      ewdata = gnt_any ? (win ? wd1 : wd0) : 32'h0;
      checks++;
      if ({a_m1_gnt, a_m0_gnt} !== {gnt_any && win, gnt_any && !win}) begin
        errors++; $display("FAIL rand_gnt[%0d]: got %b want %b", c, {a_m1_gnt, a_m0_gnt}, {gnt_any && win, gnt_any && !win});
      end
      checks++;
      if (a_mem_we !== ewe || a_mem_addr !== eaddr || a_mem_wdata !== ewdata) begin
        errors++; $display("FAIL rand_mem[%0d]: got %b/%h/%h want %b/%h/%h", c, a_mem_we, a_mem_addr, a_mem_wdata, ewe, eaddr, ewdata);
      end
      checks++;
      if ({a_m1_rvalid, a_m0_rvalid} !== {(c == rv_at) && rv_owner, (c == rv_at) && !rv_owner}) begin
        errors++; $display("FAIL rand_rvalid[%0d]: got %b want %b", c, {a_m1_rvalid, a_m0_rvalid}, {(c == rv_at) && rv_owner, (c == rv_at) && !rv_owner});
      end
      if (c == rv_at) begin
        checks++;
        if ((rv_owner ? a_m1_rdata : a_m0_rdata) !== rv_data) begin
          errors++; $display("FAIL rand_rdata[%0d]: got %h want %h", c, rv_owner ? a_m1_rdata : a_m0_rdata, rv_data);
        end
      end
      if (gnt_any) begin
        last = win;
        if (ewe) begin
          mdl[eaddr[9:2]] = ewdata;
          free_at = c + 1;
        end else begin
          rv_at = c + LAT; rv_owner = win; rv_data = mdl[eaddr[9:2]];
          free_at = c + LAT + 1;
        end
        if (win) p1 = 1'b0; else p0 = 1'b0;
      end
      next_cycle();
    end
    a_m0_req = 1'b0; a_m1_req = 1'b0;
    repeat (3) next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    a_m0_req = 1'b0; a_m0_we = 1'b0; a_m0_addr = 32'h0; a_m0_wdata = 32'h0;
    a_m1_req = 1'b0; a_m1_we = 1'b0; a_m1_addr = 32'h0; a_m1_wdata = 32'h0;
    b_m0_req = 1'b0; b_m0_we = 1'b0; b_m0_addr = 32'h0; b_m0_wdata = 32'h0;
    b_m1_req = 1'b0; b_m1_we = 1'b0; b_m1_addr = 32'h0; b_m1_wdata = 32'h0;
    test_reset();
    test_read();
    test_back_to_back();
    test_lat3_contention();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
